// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply and restoring divide, WIDTH+1 cycle latency.
// Optional feature macro: MULTDIV_DIV_EN compiles in the divider; without it ctrl_DIV is ignored.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, next_state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi, lo, opd;
    logic               neg;
    logic               start, start_div, finish;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_signed;
    logic               mul_ovf;

`ifdef MULTDIV_DIV_EN
    logic               op_div, div_zero;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [WIDTH-1:0]   quot_signed;

    assign start_div   = ctrl_DIV & ~ctrl_MULT;
    assign div_shift   = {hi, lo[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, opd};
    assign quot_signed = neg ? -lo : lo;
`else
    logic               unused_div;

    assign unused_div = ctrl_DIV;
    assign start_div  = 1'b0;
`endif

    assign start  = (state != RUN) && (ctrl_MULT || start_div);
    assign finish = (state == RUN) && (count == '0);
    assign a_mag  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // {hi, lo} holds the running product (multiply) or remainder/quotient pair (divide).
    assign mul_sum     = {1'b0, hi} + {1'b0, opd & {WIDTH{lo[0]}}};
    assign prod_signed = neg ? -{hi, lo} : {hi, lo};
    assign mul_ovf     = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (count == '0) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            opd   <= '0;
            neg   <= 1'b0;
`ifdef MULTDIV_DIV_EN
            op_div   <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else if (start) begin
            count <= CW'(WIDTH);
            hi    <= '0;
            neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            lo    <= b_mag;
            opd   <= a_mag;
`ifdef MULTDIV_DIV_EN
            op_div   <= start_div;
            div_zero <= (data_operandB == '0);
            if (start_div) begin
                lo  <= a_mag;
                opd <= b_mag;
            end
`endif
        end else if ((state == RUN) && (count != '0)) begin
            count <= count - CW'(1);
            hi    <= mul_sum[WIDTH:1];
            lo    <= {mul_sum[0], lo[WIDTH-1:1]};
`ifdef MULTDIV_DIV_EN
            // Restoring step: keep the trial difference only when it did not go negative.
            if (op_div) begin
                hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], ~div_diff[WIDTH]};
            end
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= finish;
            busy           <= (next_state == RUN);
            if (finish) begin
                data_result    <= prod_signed[WIDTH-1:0];
                data_exception <= mul_ovf;
`ifdef MULTDIV_DIV_EN
                // A positive quotient with the top bit set only arises from MIN / -1.
                if (op_div) begin
                    data_result    <= div_zero ? '0 : quot_signed;
                    data_exception <= div_zero | (~neg & lo[WIDTH-1]);
                end
`endif
            end
        end
    end
endmodule
